// File: rtl/seq_multiply.sv
// seq_multiply: iterative shift-add signed/unsigned multiplier with valid/ready handshake.
// Presents the extended product on acc_term only in the cycle it is consumed.
module seq_multiply #(
    parameter int MAC_MIN_WIDTH = 8,
    parameter int MAC_MUL_WIDTH = 2 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MAC_MUL_WIDTH-1:0] a,
    input  logic [MAC_MUL_WIDTH-1:0] b,
    input  logic                     is_signed,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MAC_ACC_WIDTH-1:0] product,
    output logic [MAC_ACC_WIDTH-1:0] acc_term
);
    localparam int W  = MAC_MUL_WIDTH;
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t                   r_state, w_next;
    logic [CW-1:0]            r_cnt;
    logic [W-1:0]             r_mcand, r_hi, r_lo;
    logic                     r_neg, r_signed;
    logic [MAC_ACC_WIDTH-1:0] r_product;
    logic                     w_accept;
    logic [W:0]               w_sum;
    logic [2*W-1:0]           w_mag, w_res;

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;

    always_comb begin
        w_next = (r_state == IDLE) ? (in_valid ? BUSY : IDLE) :
                 (r_state == BUSY) ? (r_cnt == '0 ? DONE : BUSY) :
                 (r_state == DONE) ? (out_ready ? (in_valid ? BUSY : IDLE) : DONE) : IDLE;
    end

    always_comb begin
        in_ready  = (r_state == IDLE) || (r_state == DONE && out_ready);
        out_valid = (r_state == DONE);
        product   = r_product;
        acc_term  = (out_valid && out_ready) ? r_product : '0;
    end

    assign w_accept = in_valid && in_ready;
    // Right-shifting accumulator: the multiplier drains out of r_lo as product bits fill in.
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_mag    = {w_sum, r_lo[W-1:1]};
    assign w_res    = r_neg ? -w_mag : w_mag;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg     <= 1'b0;
            r_signed  <= 1'b0;
            r_product <= '0;
        end else if (w_accept) begin
            r_cnt    <= CW'(W - 1);
            r_mcand  <= (is_signed && a[W-1]) ? -a : a;
            r_lo     <= (is_signed && b[W-1]) ? -b : b;
            r_hi     <= '0;
            r_neg    <= is_signed && (a[W-1] ^ b[W-1]);
            r_signed <= is_signed;
        end else if (r_state == BUSY) begin
            r_hi  <= w_sum[W:1];
            r_lo  <= {w_sum[0], r_lo[W-1:1]};
            r_cnt <= (r_cnt == '0) ? '0 : r_cnt - 1'b1;
            if (r_cnt == '0)
                r_product <= r_signed ? MAC_ACC_WIDTH'($signed(w_res)) : MAC_ACC_WIDTH'(w_res);
        end
endmodule

// File: tb/tb_seq_multiply.sv
// tb_seq_multiply: directed self-checking bench for seq_multiply.
module tb_seq_multiply;
    logic        clk, rst, in_valid, in_ready, is_signed, out_valid, out_ready;
    logic [15:0] a, b;
    logic [31:0] product, acc_term;
    int          checks = 0;
    int          failures = 0;

    seq_multiply dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .acc_term(acc_term)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] x, input logic [15:0] y, input logic s, output int n);
        in_valid = 1'b1; a = x; b = y; is_signed = s;
        step;
        in_valid = 1'b0; a = ~x; b = 16'h5A5A; is_signed = ~s;
        n = 0;
        while (!out_valid && n < 40) begin
            step;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        step; step;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (product !== 32'h0) begin failures++; $display("FAIL reset_product got=%h want=0", product); end
        checks++; if (acc_term !== 32'h0) begin failures++; $display("FAIL reset_acc_term got=%h want=0", acc_term); end
        rst = 1'b1;
        step;
    endtask

    task automatic test_unsigned;
        int n, nz;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'd3; b = 16'd5; is_signed = 1'b0;
        step;
        in_valid = 1'b0; a = 16'hFFFF; b = 16'hFFFF; is_signed = 1'b1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL busy_in_ready got=%b want=0", in_ready); end
        n = 0; nz = 0;
        while (!out_valid && n < 40) begin
            if (acc_term !== 32'h0) nz++;
            step;
            n++;
        end
        checks++; if (n !== 16) begin failures++; $display("FAIL u3x5_latency got=%0d want=16", n); end
        checks++; if (product !== 32'h0000000F) begin failures++; $display("FAIL u3x5_product got=%h want=0000000f", product); end
        checks++; if (acc_term !== 32'h0000000F) begin failures++; $display("FAIL u3x5_acc_term got=%h want=0000000f", acc_term); end
        step;
        checks++; if (out_valid !== 1'b0 || acc_term !== 32'h0 || nz !== 0) begin failures++; $display("FAIL u3x5_after got valid=%b acc=%h early=%0d want 0", out_valid, acc_term, nz); end
        run(16'hFFFF, 16'hFFFF, 1'b0, n);
        checks++; if (n !== 16 || product !== 32'hFFFE0001) begin failures++; $display("FAIL umax got lat=%0d prod=%h want 16 fffe0001", n, product); end
        step;
    endtask

    task automatic test_signed;
        logic [15:0] xa [3] = '{16'hFFFD, 16'h8000, 16'h8000};
        logic [15:0] xb [3] = '{16'h0005, 16'h8000, 16'h0001};
        logic [31:0] exp [3] = '{32'hFFFFFFF1, 32'h40000000, 32'hFFFF8000};
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run(xa[i], xb[i], 1'b1, n);
            checks++; if (n !== 16 || product !== exp[i]) begin failures++; $display("FAIL signed_%0d got lat=%0d prod=%h want 16 %h", i, n, product, exp[i]); end
            checks++; if (acc_term !== exp[i]) begin failures++; $display("FAIL signed_acc_%0d got=%h want=%h", i, acc_term, exp[i]); end
            step;
        end
    endtask

    task automatic test_backpressure;
        int n;
        out_ready = 1'b0;
        run(16'd100, 16'd3, 1'b0, n);
        checks++; if (n !== 16) begin failures++; $display("FAIL bp_latency got=%0d want=16", n); end
        in_valid = 1'b1; a = 16'd7; b = 16'd9;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || product !== 32'd300 || acc_term !== 32'h0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d got v=%b p=%h acc=%h rdy=%b want 1 12c 0 0", i, out_valid, product, acc_term, in_ready);
            end
            step;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (acc_term !== 32'd300) begin failures++; $display("FAIL bp_release got=%h want=12c", acc_term); end
        step;
        checks++; if (out_valid !== 1'b0 || acc_term !== 32'h0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_after got v=%b acc=%h rdy=%b want 0 0 1", out_valid, acc_term, in_ready); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] xa [3] = '{16'd2, 16'd0, 16'hFFFF};
        logic [15:0] xb [3] = '{16'd7, 16'h1234, 16'd1};
        logic [31:0] exp [3] = '{32'd14, 32'd0, 32'h0000FFFF};
        int n;
        out_ready = 1'b1; is_signed = 1'b0;
        in_valid = 1'b1; a = xa[0]; b = xb[0];
        step;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin a = xa[i+1]; b = xb[i+1]; end
            else in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 40) begin
                step;
                n++;
            end
            checks++; if (n !== 16) begin failures++; $display("FAIL b2b_spacing_%0d got=%0d want=16", i, n + 1); end
            checks++; if (product !== exp[i] || acc_term !== exp[i]) begin failures++; $display("FAIL b2b_result_%0d got p=%h acc=%h want %h", i, product, acc_term, exp[i]); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_%0d got=%b want=1", i, in_ready); end
            step;
        end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_end got v=%b rdy=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_reset_busy;
        int n, seen;
        out_ready = 1'b1; is_signed = 1'b0;
        in_valid = 1'b1; a = 16'h1234; b = 16'h0010;
        step;
        in_valid = 1'b0;
        repeat (8) step;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 32'h0 || acc_term !== 32'h0) begin
            failures++;
            $display("FAIL rst_busy got rdy=%b v=%b p=%h acc=%h want 1 0 0 0", in_ready, out_valid, product, acc_term);
        end
        step;
        rst = 1'b1;
        seen = 0;
        repeat (20) begin
            step;
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rst_no_result got=%0d want=0", seen); end
        run(16'd6, 16'd7, 1'b0, n);
        checks++; if (n !== 16 || product !== 32'd42) begin failures++; $display("FAIL rst_next got lat=%0d p=%h want 16 2a", n, product); end
        step;
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_backpressure;
        test_back_to_back;
        test_reset_busy;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_multiply.md
# seq_multiply

Iterative shift-add multiplier sitting directly upstream of the `accumulate` stage in the MAC datapath. It accepts one pair of operands per transaction over a valid/ready handshake and computes a signed or unsigned product over `MAC_MUL_WIDTH` cycles. It presents the product, sign- or zero-extended to accumulator width, on `acc_term`, which drives the accumulator's `acc_in`. `acc_term` is zero in every cycle in which no product is consumed, so the accumulator may add on every clock.

## Interface
- `MAC_MIN_WIDTH`, 8, base MAC lane width.
- `MAC_MUL_WIDTH`, 2*MAC_MIN_WIDTH, operand width W; also the multiply latency in cycles.
- `MAC_ACC_WIDTH`, 4*MAC_MIN_WIDTH, result width; must be ≥ 2*MAC_MUL_WIDTH.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserts immediately when low; released synchronously by the integrator).
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands this cycle.
- `a`  in  W  multiplicand.
- `b`  in  W  multiplier.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `a`/`b`.
- `out_valid`  out  1  `product` holds a finished result.
- `out_ready`  in  1  consumer (accumulator control) takes the result this cycle.
- `product`  out  MAC_ACC_WIDTH  registered result, extended to full width.
- `acc_term`  out  MAC_ACC_WIDTH  `product` when `out_valid & out_ready`, else 0; drives accumulator `acc_in`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: `in_ready`=1. If `in_valid`, latch operands and `is_signed` -> BUSY.
- BUSY: `in_ready`=0, `out_valid`=0. Performs one shift-add step per cycle for W cycles, driven by a counter loaded with W-1. At the edge where the counter reaches 0, `product` is written with the final, sign-corrected value -> DONE.
- DONE: `out_valid`=1 and `product` is held stable.
  - `out_ready`=0: stay in DONE; `in_ready`=0.
  - `out_ready`=1, `in_valid`=0: -> IDLE.
  - `out_ready`=1, `in_valid`=1: `in_ready`=1; the new operands are latched in the same cycle -> BUSY (back-to-back).
- Signed mode:
  - Operate on magnitudes; negate = `a[W-1] ^ b[W-1]`.
  - Magnitude of -2^(W-1) is 2^(W-1) and must be represented as unsigned W bits without overflow.
  - The 2W-bit result is sign-extended to `MAC_ACC_WIDTH`.
- Unsigned mode: the 2W-bit result is zero-extended to `MAC_ACC_WIDTH`.
- No overflow is possible: the 2W-bit result is exact in both modes.
- `acc_term` is purely combinational from registered state and `out_ready`.

## Timing
- Reset values (while `rst`=0): state=IDLE, `in_ready`=1, `out_valid`=0, `product`=0, `acc_term`=0, counter=0.
- Reset asserted mid-BUSY or in DONE: the operation is abandoned and no result is delivered.
- Latency: with operands accepted at edge e0, `out_valid` rises after edge e0+W, i.e. W cycles later (16 cycles for default W=16).
- Throughput: one result per W+1 cycles when `out_ready` is held at 1 with back-to-back `in_valid`. A new accept coincides with the consume cycle.
- `a`, `b`, `is_signed` are don't-care outside the accept cycle. Changes during BUSY must not affect the result.
- `in_valid` asserted during BUSY is ignored (`in_ready`=0). The producer holds its request until `in_ready`=1.
- Exactly one nonzero-capable `acc_term` cycle occurs per transaction.

## Test plan
- Unsigned 3×5 (`is_signed`=0), `out_ready`=1:
  - `out_valid` high exactly 16 cycles after the accept edge.
  - `product`=0x0000000F; `acc_term`=0x0000000F for one cycle, otherwise 0.
- Unsigned 0xFFFF×0xFFFF -> `product`=0xFFFE0001.
- Signed cases:
  - 0xFFFD×0x0005 (-3×5) -> 0xFFFFFFF1.
  - 0x8000×0x8000 -> 0x40000000.
  - 0x8000×0x0001 -> 0xFFFF8000.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid`:
  - `product` stable, `acc_term`=0, `in_ready`=0 while `in_valid`=1.
  - Raising `out_ready` gives exactly one `acc_term` cycle.
- Back-to-back: three pairs (2×7, 0×0x1234, 0xFFFF×1 unsigned) with continuous `in_valid`/`out_ready`:
  - Results 14, 0, 0xFFFF.
  - Spaced 17 cycles apart; new accept in the same cycle as each consume.
- Reset mid-BUSY (cycle 8 of 16):
  - Outputs return to reset values asynchronously; no `out_valid` follows.
  - Next transaction 6×7 -> 42 with nominal latency.
